l2_fill_responder: RTL

Next-level responder for instruction-cache miss fills. Accepts 26-bit line-fill addresses from the instruction cache over a valid/ready handshake and buffers them in a small FIFO. Services them in order after a fixed modelled memory latency, and returns each completed fill over a second valid/ready handshake. Sits between the instruction cache and the statistics module, and also counts completed fills.

---
 rtl/l2_fill_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/l2_fill_responder.sv
// l2_fill_responder
//
// Next-level responder for instruction-cache line fills. Fill addresses are
// accepted over a valid/ready handshake into a small in-order FIFO. Each one
// is serviced after a fixed modelled memory latency. The completed fill is
// then returned over a second valid/ready handshake. Completed fills are
// counted.
//
// Optional feature macro: L2_MERGE_EN
//   defined   : a request matching a queued entry or the fill in flight is
//               acknowledged but not enqueued, and merge_count_o counts it
//   undefined : every accepted request is enqueued, merge_count_o is 0
//
// Ports
//   clk_i          single clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   req_valid_i    fill request present
//   req_addr_i     fill line address
//   req_ready_o    request accepted when high together with req_valid_i
//   rsp_valid_o    fill response present
//   rsp_addr_o     address of completed fill (meaningful while rsp_valid_o)
//   rsp_ready_i    consumer takes the response
//   fill_count_o   completed fills, wraps at 2^32
//   merge_count_o  merged duplicate requests, saturates at 0xFFFF
//   busy_o         FIFO non-empty or a fill in flight
//
// state     | meaning
// ST_IDLE   | nothing in flight; pops the FIFO head when one is queued
// ST_WAIT   | modelled memory latency counting down
// ST_RESP   | response presented, held until rsp_ready_i

module l2_fill_responder #(
  parameter int ADDR_W  = 26,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       fill_count_o,
  output logic [15:0]       merge_count_o,
  output logic              busy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [31:0]         fill_count_q, fill_count_d;

  logic [ADDR_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]    occ_q;

  logic full, empty, accept, dup, push, pop;

  assign full        = (occ_q == OCC_FULL);
  assign empty       = (occ_q == '0);
  assign req_ready_o = rst_n_i && !full;
  assign accept      = req_valid_i && req_ready_o;
  assign push        = accept && !dup;

`ifdef L2_MERGE_EN
  logic [15:0] merge_count_q;

  // An entry is live when its distance from the read pointer is below the
  // occupancy. The head being popped this cycle still counts: it is about to
  // become the fill in flight.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < occ_q) &&
          (mem_q[i] == req_addr_i)) begin
        dup = 1'b1;
      end
    end
    if ((state_q != ST_IDLE) && (cur_addr_q == req_addr_i)) begin
      dup = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      merge_count_q <= '0;
    end else if (accept && dup && (merge_count_q != 16'hFFFF)) begin
      merge_count_q <= merge_count_q + 16'd1;
    end
  end

  assign merge_count_o = merge_count_q;
`else
  assign dup           = 1'b0;
  assign merge_count_o = '0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_addr_d   = cur_addr_q;
    fill_count_d = fill_count_q;
    pop          = 1'b0;
    rsp_valid_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          cur_addr_d = mem_q[rd_ptr_q];
          cnt_d      = CNT_INIT;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          fill_count_d = fill_count_q + 32'd1;
          // Chain straight into the next fill so throughput is LATENCY+1.
          if (!empty) begin
            pop        = 1'b1;
            cur_addr_d = mem_q[rd_ptr_q];
            cnt_d      = CNT_INIT;
            state_d    = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_addr_q   <= '0;
      fill_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_addr_q   <= cur_addr_d;
      fill_count_q <= fill_count_d;
    end
  end

  // Storage needs no reset: only entries inside the occupancy window are read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign rsp_addr_o   = cur_addr_q;
  assign fill_count_o = fill_count_q;
  assign busy_o       = !empty || (state_q != ST_IDLE);

endmodule
